// File: rtl/watch_set_if.sv
// Signal bundle between the watch mode/sequencing controller and the counter chain.
// Latency: none; wires only.
// Backpressure: none; every signal is a level or a single-cycle strobe.
interface watch_set_if;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_clr;
    logic       sec_carry;
    logic       min_carry;
    logic       sec_pls;
    logic       min_pls;
    logic       hr_pls;
    logic       sec_clr;
    logic       min_clr;
    logic       hr_clr;
    logic [1:0] mode;

    // Environment side: drives tick, buttons and carries, observes the counter controls.
    modport master (
        output tick_1hz, btn_mode, btn_inc, btn_clr, sec_carry, min_carry,
        input  sec_pls, min_pls, hr_pls, sec_clr, min_clr, hr_clr, mode
    );

    // Controller side.
    modport slave (
        input  tick_1hz, btn_mode, btn_inc, btn_clr, sec_carry, min_carry,
        output sec_pls, min_pls, hr_pls, sec_clr, min_clr, hr_clr, mode
    );
endinterface

// File: rtl/watch_set_ctrl.sv
// Mode/sequencing controller feeding widened count and clear pulses to the hr/min/sec counters.
// Latency: 1 cycle from tick, button rise or carry to the registered outputs (longer when deferred).
// Backpressure: one increment request is latched while a pulse is busy, extras dropped; clears are deferred, never dropped.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat on btn_inc in the set modes.
module watch_set_ctrl #(
    parameter int PLS_W      = 4,         // high width and low gap of each pulse, >= 2
    parameter int REPEAT_DLY = 25000000,  // hold time before auto-repeat starts
    parameter int REPEAT_PER = 5000000    // auto-repeat period
) (
    input  logic       clk,
    input  logic       rst,
    watch_set_if.slave io_ws
);
    localparam int               CNT_W    = (PLS_W > 1) ? $clog2(PLS_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PLS_W - 1);

    typedef enum logic [1:0] {
        M_RUN     = 2'd0,
        M_SET_HR  = 2'd1,
        M_SET_MIN = 2'd2,
        M_SET_SEC = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_HIGH = 2'd1,
        G_LOW  = 2'd2
    } gen_t;

    // Button edge detection
    logic r_mode_q, r_inc_q, r_clr_q;
    logic w_mode_rise, w_inc_rise, w_clr_rise;

    // Mode FSM
    mode_t r_mode, w_mode_nxt;
    logic  r_mode_pend, w_mode_pend_nxt, w_mode_adv;

    // Pulse generator
    gen_t             r_gen, w_gen_nxt;
    logic [CNT_W-1:0] r_gen_cnt, w_gen_cnt_nxt;
    logic             r_req_pend, w_req_pend_nxt;
    logic             w_gen_start, w_gen_hi, w_req, w_rep_fire;

    // Clear sequencer; bit order {hr, min, sec}
    logic [2:0]       r_clr_out, r_clr_pend_mask, w_clr_sel, w_clr_start_mask;
    logic [CNT_W-1:0] r_clr_cnt;
    logic             r_clr_pend, w_clr_busy, w_clr_req, w_clr_start;

    // Count outputs and their source locks; bit order {hr, min, sec}
    logic [2:0] r_pls, r_lock, w_src, w_track, w_pls_nxt, w_lock_nxt;

    // Capture previous button levels for rise detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode_q <= 1'b0;
            r_inc_q  <= 1'b0;
            r_clr_q  <= 1'b0;
        end else begin
            r_mode_q <= io_ws.btn_mode;
            r_inc_q  <= io_ws.btn_inc;
            r_clr_q  <= io_ws.btn_clr;
        end
    end

    assign w_mode_rise = io_ws.btn_mode & ~r_mode_q;
    assign w_inc_rise  = io_ws.btn_inc  & ~r_inc_q;
    assign w_clr_rise  = io_ws.btn_clr  & ~r_clr_q;

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_on;

    // First repeat after REPEAT_DLY cycles of hold, then every REPEAT_PER cycles
    assign w_rep_fire = io_ws.btn_inc & ~w_inc_rise & (r_mode != M_RUN) &
                        (r_rep_cnt == (r_rep_on ? REP_W'(REPEAT_PER) : REP_W'(REPEAT_DLY)));

    // Hold-time counter, restarted by each rise or repeat and cleared on release or in RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rep_cnt <= '0;
            r_rep_on  <= 1'b0;
        end else if (!io_ws.btn_inc || r_mode == M_RUN) begin
            r_rep_cnt <= '0;
            r_rep_on  <= 1'b0;
        end else if (w_inc_rise) begin
            r_rep_cnt <= REP_W'(1);
            r_rep_on  <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_cnt <= REP_W'(1);
            r_rep_on  <= 1'b1;
        end else begin
            r_rep_cnt <= r_rep_cnt + REP_W'(1);
        end
    end
`else
    logic w_unused_rep;
    assign w_rep_fire   = 1'b0;
    assign w_unused_rep = ^{REPEAT_DLY, REPEAT_PER};
`endif

    // Time ticks only in RUN; increments only in the set modes
    assign w_req = (r_mode == M_RUN) ? io_ws.tick_1hz : (w_inc_rise | w_rep_fire);

    // Clear targets for a rise in the current mode
    always_comb begin
        w_clr_sel = 3'b111;
        case (r_mode)
            M_SET_HR:  w_clr_sel = 3'b100;
            M_SET_MIN: w_clr_sel = 3'b010;
            M_SET_SEC: w_clr_sel = 3'b001;
            default:   w_clr_sel = 3'b111;
        endcase
    end

    // A clear only starts with the generator idle and no clear already running
    assign w_clr_busy       = |r_clr_out;
    assign w_clr_req        = w_clr_rise | r_clr_pend;
    assign w_clr_start      = w_clr_req & (r_gen == G_IDLE) & ~w_clr_busy;
    assign w_clr_start_mask = r_clr_pend_mask | (w_clr_rise ? w_clr_sel : 3'b000);

    // Clear pulse sequencer; targets are fixed when the clear is requested
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clr_out       <= 3'b000;
            r_clr_cnt       <= '0;
            r_clr_pend      <= 1'b0;
            r_clr_pend_mask <= 3'b000;
        end else if (w_clr_start) begin
            r_clr_out       <= w_clr_start_mask;
            r_clr_cnt       <= '0;
            r_clr_pend      <= 1'b0;
            r_clr_pend_mask <= 3'b000;
        end else begin
            if (w_clr_busy) begin
                if (r_clr_cnt == CNT_LAST) r_clr_out <= 3'b000;
                else                       r_clr_cnt <= r_clr_cnt + CNT_W'(1);
            end
            if (w_clr_rise) begin
                r_clr_pend      <= 1'b1;
                r_clr_pend_mask <= r_clr_pend_mask | w_clr_sel;
            end
        end
    end

    // Generator and mode state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gen       <= G_IDLE;
            r_gen_cnt   <= '0;
            r_req_pend  <= 1'b0;
            r_mode      <= M_RUN;
            r_mode_pend <= 1'b0;
        end else begin
            r_gen       <= w_gen_nxt;
            r_gen_cnt   <= w_gen_cnt_nxt;
            r_req_pend  <= w_req_pend_nxt;
            r_mode      <= w_mode_nxt;
            r_mode_pend <= w_mode_pend_nxt;
        end
    end

    // Generator sequencing, pending-request bookkeeping and deferred mode advance
    always_comb begin
        w_gen_nxt     = r_gen;
        w_gen_cnt_nxt = r_gen_cnt;
        w_gen_start   = 1'b0;
        case (r_gen)
            G_IDLE: begin
                // A clear in flight or about to start goes first; the request waits as pending
                if (~w_clr_busy & ~w_clr_req & (w_req | r_req_pend))
                    w_gen_start = 1'b1;
            end
            G_HIGH: begin
                if (r_gen_cnt == CNT_LAST) begin
                    w_gen_nxt     = G_LOW;
                    w_gen_cnt_nxt = '0;
                end else begin
                    w_gen_cnt_nxt = r_gen_cnt + CNT_W'(1);
                end
            end
            G_LOW: begin
                if (r_gen_cnt == CNT_LAST) begin
                    // Back-to-back restart unless a deferred clear needs an idle slot
                    if ((w_req | r_req_pend) & ~w_clr_req) w_gen_start = 1'b1;
                    else                                   w_gen_nxt   = G_IDLE;
                end else begin
                    w_gen_cnt_nxt = r_gen_cnt + CNT_W'(1);
                end
            end
            default: w_gen_nxt = G_IDLE;
        endcase
        if (w_gen_start) begin
            w_gen_nxt     = G_HIGH;
            w_gen_cnt_nxt = '0;
        end

        // One slot: starting consumes it, anything arriving while it is full is lost
        w_req_pend_nxt = w_gen_start ? 1'b0 : (r_req_pend | w_req);

        // Only switch routing with the generator quiet and no increment owed to the old mode
        w_mode_adv      = (w_mode_rise | r_mode_pend) & (r_gen == G_IDLE) &
                          ~w_gen_start & ~w_req & ~r_req_pend;
        w_mode_nxt      = w_mode_adv ? mode_t'(r_mode + 2'd1) : r_mode;
        w_mode_pend_nxt = ~w_mode_adv & (r_mode_pend | w_mode_rise);
    end

    assign w_gen_hi = (w_gen_nxt == G_HIGH);

    // Route nominal sources; an unlocked output holds until its source matches, so rerouting never makes a falling edge
    always_comb begin
        w_src = r_pls;
        case (r_mode)
            M_RUN:     w_src    = {io_ws.min_carry, io_ws.sec_carry, w_gen_hi};
            M_SET_HR:  w_src[2] = w_gen_hi;
            M_SET_MIN: w_src[1] = w_gen_hi;
            M_SET_SEC: w_src[0] = w_gen_hi;
            default:   w_src    = r_pls;
        endcase
        w_track    = r_lock | ~(w_src ^ r_pls);
        w_pls_nxt  = (w_track & w_src) | (~w_track & r_pls);
        w_lock_nxt = w_mode_adv ? 3'b000 : w_track;
    end

    // Registered count outputs and their lock flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pls  <= 3'b000;
            r_lock <= 3'b111;
        end else begin
            r_pls  <= w_pls_nxt;
            r_lock <= w_lock_nxt;
        end
    end

    assign io_ws.sec_pls = r_pls[0];
    assign io_ws.min_pls = r_pls[1];
    assign io_ws.hr_pls  = r_pls[2];
    assign io_ws.sec_clr = r_clr_out[0];
    assign io_ws.min_clr = r_clr_out[1];
    assign io_ws.hr_clr  = r_clr_out[2];
    assign io_ws.mode    = r_mode;
endmodule
